sb_line_tx: RTL

//  Sideband transmitter: owns the SBTX line. Holds SBTX low while disconnected and releases it high on

---
 rtl/sb_line_tx_pkg.sv | 23 ++
 rtl/sb_sat_cnt.sv | 31 +++
 rtl/sb_line_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sb_line_tx_pkg.sv
// Shared sideband TX definitions: line-state encodings, default timing
// parameters and a counter-width helper.
package sb_line_tx_pkg;

    typedef enum logic [2:0] {
        ST_DISC  = 3'd0,
        ST_CONN  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } sb_state_e;

    localparam int DEF_TDISCONNECT_TX = 50000;
    localparam int DEF_TCONNECT_TX    = 25;
    localparam int DEF_BIT_CYCLES     = 1;

    // Width needed to hold 0..max; never narrower than one bit.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/sb_sat_cnt.sv
// Saturating up-counter with synchronous clear and enable; flags when it
// sits at MAX.
module sb_sat_cnt
    import sb_line_tx_pkg::*;
#(
    parameter int MAX = 1
) (
    input  logic sb_clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    localparam int             W     = cnt_width(MAX);
    localparam logic [W-1:0]   MAX_V = W'(MAX);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sb_clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != MAX_V)) begin
            count <= count + W'(1);
        end
    end

    assign at_max = (count == MAX_V);

endmodule

// File: rtl/sb_line_tx.sv
// Sideband transmitter: owns SBTX, enforces the disconnect/connect timing and
// serialises bytes as start(0), 8 data bits LSB-first, stop(1).
module sb_line_tx
    import sb_line_tx_pkg::*;
#(
    parameter int TDISCONNECT_TX = DEF_TDISCONNECT_TX,
    parameter int TCONNECT_TX    = DEF_TCONNECT_TX,
    parameter int BIT_CYCLES     = DEF_BIT_CYCLES
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       sb_enable,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       sbtx,
    output logic       disconnected_s,
    output logic       tdisconnect_tx_min,
    output logic       tx_busy
);

    localparam int           BW       = cnt_width(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYCLES - 1);

    sb_state_e     state;
    logic [7:0]    shift_reg;
    logic [BW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic          bit_end;
    logic          dis_clr;
    logic          dis_at_max;
    logic          conn_at_max;

    assign tx_ready = (state == ST_IDLE) && sb_enable;
    assign bit_end  = (bit_cnt == BIT_LAST);

    // Clearing on the exit edge too means a quick CONN->DISC bounce can never
    // see a stale minimum flag and reconnect early.
    assign dis_clr = (state != ST_DISC) || (sb_enable && tdisconnect_tx_min);

    sb_sat_cnt #(.MAX(TDISCONNECT_TX)) u_dis_cnt (
        .sb_clk (sb_clk),
        .rst    (rst),
        .clr    (dis_clr),
        .en     (state == ST_DISC),
        .at_max (dis_at_max)
    );

    sb_sat_cnt #(.MAX(TCONNECT_TX - 1)) u_conn_cnt (
        .sb_clk (sb_clk),
        .rst    (rst),
        .clr    (state != ST_CONN),
        .en     (state == ST_CONN),
        .at_max (conn_at_max)
    );

    always_ff @(posedge sb_clk) begin
        if (rst) begin
            state              <= ST_DISC;
            sbtx               <= 1'b0;
            disconnected_s     <= 1'b1;
            tdisconnect_tx_min <= 1'b0;
            tx_busy            <= 1'b0;
            shift_reg          <= '0;
            bit_cnt            <= '0;
            bit_idx            <= '0;
        end else begin
            tdisconnect_tx_min <= dis_at_max && !dis_clr;
            case (state)
                ST_DISC: begin
                    if (sb_enable && tdisconnect_tx_min) begin
                        state          <= ST_CONN;
                        sbtx           <= 1'b1;
                        disconnected_s <= 1'b0;
                    end
                end
                ST_CONN, ST_IDLE: begin
                    if (!sb_enable) begin
                        state          <= ST_DISC;
                        sbtx           <= 1'b0;
                        disconnected_s <= 1'b1;
                    end else if (state == ST_CONN) begin
                        if (conn_at_max) state <= ST_IDLE;
                    end else if (tx_valid) begin
                        state     <= ST_START;
                        sbtx      <= 1'b0;
                        tx_busy   <= 1'b1;
                        shift_reg <= tx_data;
                        bit_cnt   <= '0;
                    end
                end
                ST_START: begin
                    bit_cnt <= bit_end ? '0 : bit_cnt + BW'(1);
                    if (bit_end) begin
                        state     <= ST_DATA;
                        sbtx      <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= '0;
                    end
                end
                ST_DATA: begin
                    bit_cnt <= bit_end ? '0 : bit_cnt + BW'(1);
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            sbtx  <= 1'b1;
                        end else begin
                            sbtx      <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    bit_cnt <= bit_end ? '0 : bit_cnt + BW'(1);
                    if (bit_end) begin
                        tx_busy <= 1'b0;
                        if (sb_enable) begin
                            state <= ST_IDLE;
                        end else begin
                            state          <= ST_DISC;
                            sbtx           <= 1'b0;
                            disconnected_s <= 1'b1;
                        end
                    end
                end
                default: begin
                    state          <= ST_DISC;
                    sbtx           <= 1'b0;
                    disconnected_s <= 1'b1;
                    tx_busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
